sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, successor to the fixed 8×8 buffer, for byte and word streams between producer and consumer blocks in one clock domain. Adds configurable width and depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a read-valid strobe. A first-word-fall-through read mode is selectable at compile time.

---
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, sticky error flags and read-valid strobe.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is a registered read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_words,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] words_reg, words_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wr_fire, rd_fire;

  assign full         = (words_reg == CW'(DEPTH));
  assign empty        = (words_reg == '0);
  assign almost_full  = (words_reg >= CW'(AF_LEVEL));
  assign almost_empty = (words_reg <= CW'(AE_LEVEL));
  assign fifo_words   = words_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Acceptance uses the registered occupancy, so full/empty never depend on this cycle's requests.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    words_next     = words_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (wr_fire) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (rd_fire) rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   words_next = words_reg + CW'(1);
      2'b01:   words_next = words_reg - CW'(1);
      default: words_next = words_reg;
    endcase
    if (clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    // A fresh error in the same cycle overrides the clear.
    if (wr_en && full)  overflow_next  = 1'b1;
    if (rd_en && empty) underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      words_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      words_reg     <= words_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) mem[wr_ptr_reg] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented asynchronously; zero while empty keeps the reset value defined.
  assign data_out = empty ? '0 : mem[rd_ptr_reg];
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] data_out_reg;
  logic             rd_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) data_out_reg <= mem[rd_ptr_reg];
    end
  end

  assign data_out = data_out_reg;
  assign rd_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in;
  logic       full, almost_full, empty, almost_empty, rd_valid;
  logic       overflow, underflow;
  logic [7:0] data_out;
  logic [4:0] fifo_words;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .fifo_words(fifo_words),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  // Monitor: every word the DUT delivers is compared with the head of the expected queue.
  always @(negedge clk) begin
`ifdef FIFO_FWFT_EN
    if (rd_valid === 1'b1 && rd_en === 1'b1) begin
`else
    if (rd_valid === 1'b1) begin
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: unexpected word 0x%0h, none expected", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h, expected 0x%0h", data_out, e);
        end else begin
          $display("ok   rd_data = 0x%0h", data_out);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests active: nothing may be accepted and no error flag may set.
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0; data_in = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    check("reset_words", fifo_words, 0);
    check("reset_empty", empty, 1);
    check("reset_aempty", almost_empty, 1);
    check("reset_full", full, 0);
    check("reset_afull", almost_full, 0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_underflow", underflow, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
      check("fill_words", fifo_words, i + 1);
      check("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
      check("fill_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
      check("fill_empty", empty, 0);
    end
    check("fill_full", full, 1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_words", fifo_words, 16);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", overflow, 0);

    // Drain 16
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_words", fifo_words, 15 - i);
      check("drain_full", full, 0);
`ifndef FIFO_FWFT_EN
      check("drain_rd_valid", rd_valid, 1);
`endif
    end
    check("drain_empty", empty, 1);
    check("drain_underflow", underflow, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
    check("idle_rd_valid", rd_valid, 0);
    check("idle_data_hold", data_out, 8'h0F);
`endif

    // Wrap-around: pointers cross index 15 -> 0 in the second round
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        cycle(1'b1, 8'(8'h10 * (r + 1) + i), 1'b0, 1'b0);
        exp_q.push_back(8'(8'h10 * (r + 1) + i));
      end
      check("wrap_peak", fifo_words, 10);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_empty", empty, 1);
    end

    // Sustained simultaneous read+write at count 5
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h30 + i));
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      exp_q.push_back(8'(8'h40 + i));
      check("rw_words", fifo_words, 5);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("rw_drained", empty, 1);

    // Read+write when full: only the read is accepted
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h60 + i));
    end
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    check("full_rw_words", fifo_words, 15);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_rw_drained", empty, 1);
    check("full_rw_ovf_cleared", overflow, 0);

    // Read+write when empty: only the write is accepted, underflow sets
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    exp_q.push_back(8'h77);
    check("empty_rw_words", fifo_words, 1);
    check("empty_rw_underflow", underflow, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("empty_rw_clr", underflow, 0);
    check("empty_rw_drained", empty, 1);

    // Underflow flag: set, clear, and set-wins-over-clear
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", underflow, 1);
    check("unf_words", fifo_words, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr", underflow, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("unf_set_beats_clr", underflow, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation while full with a write pending
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h90 + i));
    end
    rst_n = 1'b0;
    cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_words", fifo_words, 0);
    check("midrst_empty", empty, 1);
    check("midrst_overflow", overflow, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_data_out", data_out, 8'h00);

`ifdef FIFO_FWFT_EN
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    check("fwft_rd_valid", rd_valid, 1);
    check("fwft_data_out", data_out, 8'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_empty", empty, 1);
    check("fwft_rd_valid_low", rd_valid, 0);
`endif

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
